// File: rtl/gpio_cfg_serializer.sv
// Pad configuration chain transmitter: per-pad word store plus a serial
// shifter that streams every word into the chain and then strobes its latch.
module gpio_cfg_serializer #(
  parameter int NUM_PADS = 9,
  parameter int PAD_CTRL_BITS = 12,
  parameter int CLK_DIV = 2,
  parameter logic [PAD_CTRL_BITS-1:0] DEF_CFG = 12'hC00
) (
  input  logic                        mclk,
  input  logic                        resetn,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_PADS)-1:0] cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0]    cfg_wdata,
  output logic [PAD_CTRL_BITS-1:0]    cfg_rdata,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        serial_clock,
  output logic                        serial_data,
  output logic                        serial_load
);

  localparam int AW = $clog2(NUM_PADS);
  localparam int BW = $clog2(PAD_CTRL_BITS);
  localparam int DW = $clog2(2*CLK_DIV+1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD_SETUP,
    LOAD,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [PAD_CTRL_BITS-1:0] words [NUM_PADS];
  logic [AW-1:0] pad_idx;
  logic [BW-1:0] bit_idx;
  logic [DW-1:0] div_cnt;
  logic addr_ok;
  logic phase_end;
  logic last_bit;

  assign addr_ok  = int'(cfg_addr) < NUM_PADS;
  assign last_bit = (pad_idx == '0) && (bit_idx == '0);
  assign cfg_rdata = addr_ok ? words[cfg_addr] : '0;

  always_comb begin
    phase_end = 1'b0;
    unique case (state)
      SHIFT_LO, SHIFT_HI, LOAD_SETUP:
        phase_end = div_cnt == DW'(CLK_DIV-1);
      LOAD:
        phase_end = div_cnt == DW'(2*CLK_DIV-1);
      default:
        phase_end = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:       if (start) state_nx = SHIFT_LO;
      SHIFT_LO:   if (phase_end) state_nx = SHIFT_HI;
      SHIFT_HI:
        if (phase_end)
          state_nx = last_bit ? LOAD_SETUP : SHIFT_LO;
      LOAD_SETUP: if (phase_end) state_nx = LOAD;
      LOAD:       if (phase_end) state_nx = DONE;
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy         = state != IDLE;
    done         = state == DONE;
    serial_clock = state == SHIFT_HI;
    serial_load  = state == LOAD;
    serial_data  = 1'b0;
    if (state == SHIFT_LO || state == SHIFT_HI)
      serial_data = words[pad_idx][bit_idx];
  end

  // Indices only move on the falling edge, so data is stable across the rise.
  always_ff @(posedge mclk) begin
    if (!resetn) begin
      state   <= IDLE;
      div_cnt <= '0;
      pad_idx <= AW'(NUM_PADS-1);
      bit_idx <= BW'(PAD_CTRL_BITS-1);
      for (int i = 0; i < NUM_PADS; i++)
        words[i] <= DEF_CFG;
    end else begin
      state <= state_nx;
      if (state_nx != state || state == IDLE)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DW'(1);
      if (state == IDLE) begin
        pad_idx <= AW'(NUM_PADS-1);
        bit_idx <= BW'(PAD_CTRL_BITS-1);
      end else if (state == SHIFT_HI && phase_end && !last_bit) begin
        if (bit_idx == '0) begin
          bit_idx <= BW'(PAD_CTRL_BITS-1);
          pad_idx <= pad_idx - AW'(1);
        end else begin
          bit_idx <= bit_idx - BW'(1);
        end
      end
      if (cfg_we && addr_ok && state == IDLE)
        words[cfg_addr] <= cfg_wdata;
    end
  end

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Bench for gpio_cfg_serializer: random words streamed through a behavioural
// chain model, timing, busy-write blocking, mid-transfer reset, fast divider.
module tb_gpio_cfg_serializer;

  localparam int T  = 108;
  localparam int T2 = 24;

  logic mclk = 1'b0;
  logic resetn;
  logic we, start, busy, done, sclk, sdata, sload;
  logic [3:0] addr;
  logic [11:0] wdata, rdata;
  logic we2, start2, busy2, done2, sclk2, sdata2, sload2;
  logic [0:0] addr2;
  logic [11:0] wdata2, rdata2;

  gpio_cfg_serializer dut (
    .mclk(mclk), .resetn(resetn), .cfg_we(we), .cfg_addr(addr),
    .cfg_wdata(wdata), .cfg_rdata(rdata), .start(start), .busy(busy),
    .done(done), .serial_clock(sclk), .serial_data(sdata),
    .serial_load(sload)
  );

  gpio_cfg_serializer #(.NUM_PADS(2), .CLK_DIV(1)) dut2 (
    .mclk(mclk), .resetn(resetn), .cfg_we(we2), .cfg_addr(addr2),
    .cfg_wdata(wdata2), .cfg_rdata(rdata2), .start(start2), .busy(busy2),
    .done(done2), .serial_clock(sclk2), .serial_data(sdata2),
    .serial_load(sload2)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [11:0] mdl1 [9];
  logic [11:0] mdl2 [2];

  // chain monitor for the default instance
  int rises, loads, dones, viol, done_cyc, first_done;
  bit q[$];
  logic [T-1:0] chain = '0;
  logic [11:0] latched [9];
  logic p_sclk = 0, p_sdata = 0, p_load = 0;

  always @(negedge mclk) begin
    if (sclk && !p_sclk) begin
      rises++;
      q.push_back(sdata);
      chain = {chain[T-2:0], sdata};
      if (sdata !== p_sdata) viol++;
    end
    if (sload) begin
      loads++;
      if (!p_load)
        for (int p = 0; p < 9; p++) latched[p] = chain[p*12 +: 12];
    end
    if (done) begin
      if (dones == 0) first_done = cyc;
      dones++;
      done_cyc = cyc;
    end
    p_sclk = sclk; p_sdata = sdata; p_load = sload;
  end

  int rises2, dones2, viol2, done_cyc2;
  bit q2[$];
  logic p_sclk2 = 0, p_sdata2 = 0;

  always @(negedge mclk) begin
    if (sclk2 && !p_sclk2) begin
      rises2++;
      q2.push_back(sdata2);
      if (sdata2 !== p_sdata2) viol2++;
    end
    if (done2) begin
      dones2++;
      done_cyc2 = cyc;
    end
    p_sclk2 = sclk2; p_sdata2 = sdata2;
  end

  task automatic tick();
    @(negedge mclk);
    #1;
  endtask

  task automatic wr(input int a, input logic [11:0] d);
    tick(); we = 1; addr = 4'(a); wdata = d;
    tick(); we = 0;
    if (a < 9) mdl1[a] = d;
  endtask

  task automatic wr2(input int a, input logic [11:0] d);
    tick(); we2 = 1; addr2 = 1'(a); wdata2 = d;
    tick(); we2 = 0;
    mdl2[a] = d;
  endtask

  task automatic rd_chk(input string tag);
    for (int a = 0; a < 10; a++) begin
      tick(); addr = 4'(a); #1;
      chk(tag, rdata, (a < 9) ? mdl1[a] : 12'h000);
    end
  endtask

  task automatic run1(input int wr_at, input int st_at, input int rst_at,
                      output int k);
    int off;
    rises = 0; loads = 0; dones = 0; viol = 0; q.delete();
    tick(); start = 1; k = cyc;
    tick(); start = 0;
    while (dones == 0 && cyc - k < 600) begin
      tick();
      off = cyc - k;
      if (off == wr_at) begin we = 1; addr = 4'd3; wdata = 12'hFFF; end
      if (off == wr_at + 1) begin addr = 4'd9; wdata = 12'h5A5; end
      if (off == wr_at + 2) we = 0;
      if (off == st_at) start = 1;
      if (off == st_at + 1) start = 0;
      if (off == rst_at) resetn = 0;
      if (off == rst_at + 1) begin
        chk("rst_mid_out", {sclk, sdata, sload, busy, done}, 5'b0);
        resetn = 1;
        for (int i = 0; i < 9; i++) mdl1[i] = 12'hC00;
      end
    end
    if (rst_at < 0) chk("done_seen", dones, 1);
  endtask

  task automatic check1(input string tag, input int k);
    int errs;
    chk({tag, "_dones"}, dones, 1);
    chk({tag, "_lat"}, done_cyc - k, 439);
    chk({tag, "_rises"}, rises, T);
    chk({tag, "_loads"}, loads, 4);
    chk({tag, "_stable"}, viol, 0);
    errs = 0;
    for (int i = 0; i < q.size(); i++)
      if (q[i] !== mdl1[8 - i/12][11 - i%12]) errs++;
    chk({tag, "_stream"}, errs, 0);
    for (int p = 0; p < 9; p++)
      chk({tag, "_pad"}, latched[p], mdl1[p]);
    tick();
    chk({tag, "_busy_off"}, busy, 0);
  endtask

  initial begin
    int k, errs;
    logic [11:0] first, last;
    resetn = 0; we = 0; start = 0; addr = 0; wdata = 0;
    we2 = 0; start2 = 0; addr2 = 0; wdata2 = 0;
    for (int i = 0; i < 9; i++) mdl1[i] = 12'hC00;
    for (int i = 0; i < 2; i++) mdl2[i] = 12'hC00;
    repeat (3) tick();
    chk("rst_out", {sclk, sdata, sload, busy, done}, 5'b0);
    chk("rst_out2", {sclk2, sdata2, sload2, busy2, done2}, 5'b0);
    resetn = 1;
    rd_chk("rst_rd");

    run1(-10, -10, -10, k);
    check1("def", k);

    wr(0, 12'hABC);
    wr(8, 12'h123);
    run1(50, 100, -10, k);
    check1("pat", k);
    first = '0; last = '0;
    if (q.size() == T)
      for (int i = 0; i < 12; i++) begin
        first = {first[10:0], q[i]};
        last  = {last[10:0], q[T-12+i]};
      end
    chk("pat_first", first, 12'h123);
    chk("pat_last", last, 12'hABC);
    rd_chk("busy_wr");

    repeat (3) begin
      for (int p = 0; p < 9; p++) wr(p, 12'($urandom));
      wr($urandom_range(9, 15), 12'($urandom));
      rd_chk("rand_rd");
      run1(-10, -10, -10, k);
      check1("rand", k);
    end

    run1(-10, -10, 200, k);
    chk("rst_loads", loads, 0);
    chk("rst_dones", dones, 0);
    rd_chk("rst_words");
    run1(-10, -10, -10, k);
    check1("after_rst", k);

    rises = 0; dones = 0; loads = 0; q.delete();
    tick(); start = 1; k = cyc;
    while (dones < 2 && cyc - k < 1000) tick();
    start = 0;
    chk("held_first", first_done - k, 439);
    chk("held_gap", done_cyc - first_done, 440);
    chk("held_rises", rises, 2*T);
    repeat (3) tick();
    chk("held_idle", busy, 0);

    wr2(0, 12'($urandom));
    wr2(1, 12'($urandom));
    rises2 = 0; dones2 = 0; viol2 = 0; q2.delete();
    tick(); start2 = 1; k = cyc;
    tick(); start2 = 0;
    while (dones2 == 0 && cyc - k < 100) tick();
    chk("d1_done", dones2, 1);
    chk("d1_lat", done_cyc2 - k, 52);
    chk("d1_rises", rises2, T2);
    chk("d1_stable", viol2, 0);
    errs = 0;
    for (int i = 0; i < q2.size(); i++)
      if (q2[i] !== mdl2[1 - i/12][11 - i%12]) errs++;
    chk("d1_stream", errs, 0);
    tick();
    chk("d1_busy_off", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
